// File: rtl/mem_access_unit_if.sv
// Bus bundle between the CPU datapath, mem_access_unit and the data RAM.
//   CPU side : req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//              resp_valid/resp_rdata/resp_err
//   RAM side : mem_addr/mem_we/mem_wdata (driven by the unit), mem_rdata (from RAM)
// Modports:
//   slave  - the mem_access_unit view (accepts requests, drives RAM)
//   master - the requester/environment view (issues requests, models RAM)
interface mem_access_unit_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [31:0]              req_wdata;
  logic                     resp_valid;
  logic [31:0]              resp_rdata;
  logic                     resp_err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_we;
  logic [31:0]              mem_wdata;
  logic [31:0]              mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU datapath and a byte-addressed data RAM.
// Accepts one RV32I load/store per valid/ready handshake, checks funct3 and the
// address window [RAM_BASE, RAM_TOP], performs the RAM access (SB/SH through a
// read-modify-write of the containing word) and returns a one-cycle resp_valid.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - mem_access_unit_if.slave (CPU request/response + RAM address/data)
module mem_access_unit #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_BASE      = 32'h0000_1000,
  parameter logic [ADDRESS_WIDTH-1:0] RAM_TOP       = 32'h0000_1FFF
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.slave    bus
);

  localparam int unsigned AW1 = ADDRESS_WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]               state;
  logic                     we_q;
  logic [2:0]               funct3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              wdata_q;
  logic [31:8]              old_q;
  logic [31:0]              resp_rdata_q;
  logic                     resp_err_q;

  // Request legality, evaluated on the incoming request
  logic           funct3_ok;
  logic [AW1-1:0] size_m1;
  logic [AW1-1:0] addr_ext;
  logic [AW1-1:0] last_ext;
  logic           in_range;
  logic           req_err;

  always_comb begin
    funct3_ok = 1'b0;
    size_m1   = '0;
    case (bus.req_funct3)
      3'b000: begin funct3_ok = 1'b1;        size_m1 = AW1'(0); end
      3'b001: begin funct3_ok = 1'b1;        size_m1 = AW1'(1); end
      3'b010: begin funct3_ok = 1'b1;        size_m1 = AW1'(3); end
      3'b100: begin funct3_ok = !bus.req_we; size_m1 = AW1'(0); end
      3'b101: begin funct3_ok = !bus.req_we; size_m1 = AW1'(1); end
      default: begin funct3_ok = 1'b0;       size_m1 = '0;      end
    endcase
  end

  // One extra bit so an access running past the top of the address space
  // cannot wrap back into the window.
  assign addr_ext = {1'b0, bus.req_addr};
  assign last_ext = addr_ext + size_m1;
  assign in_range = (addr_ext >= {1'b0, RAM_BASE}) && (last_ext <= {1'b0, RAM_TOP});
  assign req_err  = !funct3_ok || !in_range;

  // Load extension of the RAM word read in RD (byte/half always at bits [7:0]/[15:0]
  // because the RAM returns the word starting at the request address).
  logic [31:0] load_ext;
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
      3'b001:  load_ext = {{16{bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      3'b010:  load_ext = bus.mem_rdata;
      3'b100:  load_ext = {24'h0, bus.mem_rdata[7:0]};
      3'b101:  load_ext = {16'h0, bus.mem_rdata[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            if (req_err) begin
              state        <= RESP;
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end else if (bus.req_we && bus.req_funct3 == 3'b010) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          old_q <= bus.mem_rdata[31:8];
          if (we_q) begin
            state <= WR;
          end else begin
            state        <= RESP;
            resp_rdata_q <= load_ext;
            resp_err_q   <= 1'b0;
          end
        end
        WR: begin
          state        <= RESP;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write data merges the captured old word for partial stores
  logic [31:0] wr_data;
  always_comb begin
    case (funct3_q)
      3'b000:  wr_data = {old_q[31:8],  wdata_q[7:0]};
      3'b001:  wr_data = {old_q[31:16], wdata_q[15:0]};
      default: wr_data = wdata_q;
    endcase
  end

  // mem_we decodes straight from state so an asynchronous reset drops it at once
  assign bus.mem_we     = (state == WR);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = (state == WR) ? wr_data : '0;
  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a byte-addressed RAM model
// covering 0x1000..0x1FFF (plus three spill bytes for words at the top).
module tb_mem_access_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   we_count;

  mem_access_unit_if #(.ADDRESS_WIDTH(32)) bus ();

  mem_access_unit #(
    .ADDRESS_WIDTH(32),
    .RAM_BASE(32'h0000_1000),
    .RAM_TOP(32'h0000_1FFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:4098];

  function automatic logic [31:0] get_word(input logic [31:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) begin
      if (a + k >= 32'h1000 && a + k <= 32'h2002)
        w[8*k +: 8] = ram[int'(a + k - 32'h1000)];
    end
    return w;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      ram[int'(a + k - 32'h1000)] = w[8*k +: 8];
  endtask

  always_comb bus.mem_rdata = get_word(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_we) begin
      we_count <= we_count + 1;
      for (int k = 0; k < 4; k++) begin
        if (bus.mem_addr + k >= 32'h1000 && bus.mem_addr + k <= 32'h2002)
          ram[int'(bus.mem_addr + k - 32'h1000)] <= bus.mem_wdata[8*k +: 8];
      end
    end
  end

  // Issue one request, return latency (0 = no response), response and RAM write cycles
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err, output int wes);
    int we_start;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    we_start       = we_count;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = i;
        break;
      end
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    wes   = we_count - we_start;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp got=%h/%b exp=0/0", bus.resp_rdata, bus.resp_err); end
  endtask

  task automatic test_lw();
    int lat, wes; logic [31:0] rd; logic err;
    set_word(32'h1000, 32'h1234_5678);
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL lw_data got=%h exp=12345678", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", err); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (wes !== 0) begin failures++; $display("FAIL lw_no_write got=%0d exp=0", wes); end
  endtask

  task automatic test_lb_lh();
    int lat, wes; logic [31:0] rd; logic err;
    set_word(32'h1004, 32'h8001_0080);
    do_req(1'b0, 3'b000, 32'h1004, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_sext got=%h exp=ffffff80", rd); end
    do_req(1'b0, 3'b100, 32'h1004, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'h0000_0080) begin failures++; $display("FAIL lbu_zext got=%h exp=00000080", rd); end
    do_req(1'b0, 3'b001, 32'h1006, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_sext got=%h exp=ffff8001", rd); end
    do_req(1'b0, 3'b101, 32'h1006, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'h0000_8001) begin failures++; $display("FAIL lhu_zext got=%h exp=00008001", rd); end
    // misaligned halfword spanning bytes 0x1005/0x1006 = 00 01
    do_req(1'b0, 3'b001, 32'h1005, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'h0000_0100 || err !== 1'b0) begin failures++; $display("FAIL lh_misaligned got=%h/%b exp=00000100/0", rd, err); end
  endtask

  task automatic test_sb_sh_rmw();
    int lat, wes; logic [31:0] rd; logic err;
    set_word(32'h1010, 32'hAABB_CCDD);
    do_req(1'b1, 3'b000, 32'h1010, 32'hFFFF_FF11, lat, rd, err, wes);
    checks++; if (get_word(32'h1010) !== 32'hAABB_CC11) begin failures++; $display("FAIL sb_ram got=%h exp=aabbcc11", get_word(32'h1010)); end
    checks++; if (wes !== 1) begin failures++; $display("FAIL sb_we_cycles got=%0d exp=1", wes); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL sb_resp got=%h/%b exp=0/0", rd, err); end
    set_word(32'h1014, 32'h1122_3344);
    do_req(1'b1, 3'b001, 32'h1014, 32'h5555_BEEF, lat, rd, err, wes);
    checks++; if (get_word(32'h1014) !== 32'h1122_BEEF) begin failures++; $display("FAIL sh_ram got=%h exp=1122beef", get_word(32'h1014)); end
    checks++; if (lat !== 3 || wes !== 1) begin failures++; $display("FAIL sh_timing got=%0d/%0d exp=3/1", lat, wes); end
  endtask

  task automatic test_sw_lw_top();
    int lat, wes; logic [31:0] rd; logic err;
    do_req(1'b1, 3'b010, 32'h1FFC, 32'hDEAD_BEEF, lat, rd, err, wes);
    checks++; if (lat !== 2 || wes !== 1 || err !== 1'b0) begin failures++; $display("FAIL sw_top got=lat%0d/we%0d/err%b exp=2/1/0", lat, wes, err); end
    do_req(1'b0, 3'b010, 32'h1FFC, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL lw_top got=%h exp=deadbeef", rd); end
    do_req(1'b0, 3'b001, 32'h1FFE, 32'h0, lat, rd, err, wes);
    checks++; if (rd !== 32'hFFFF_DEAD || err !== 1'b0) begin failures++; $display("FAIL lh_top got=%h/%b exp=ffffdead/0", rd, err); end
    do_req(1'b1, 3'b010, 32'h1FFD, 32'h1234_5678, lat, rd, err, wes);
    checks++; if (err !== 1'b1 || wes !== 0 || lat !== 1) begin failures++; $display("FAIL sw_over_top got=err%b/we%0d/lat%0d exp=1/0/1", err, wes, lat); end
    checks++; if (get_word(32'h1FFC) !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_over_top_ram got=%h exp=deadbeef", get_word(32'h1FFC)); end
  endtask

  task automatic test_illegal();
    int lat, wes; logic [31:0] rd; logic err;
    do_req(1'b0, 3'b010, 32'h0FFF, 32'h0, lat, rd, err, wes);
    checks++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin failures++; $display("FAIL lw_below_base got=err%b/%h/lat%0d exp=1/0/1", err, rd, lat); end
    do_req(1'b0, 3'b011, 32'h1000, 32'h0, lat, rd, err, wes);
    checks++; if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin failures++; $display("FAIL load_f3_011 got=err%b/%h/lat%0d exp=1/0/1", err, rd, lat); end
    do_req(1'b1, 3'b001, 32'h1FFF, 32'hFFFF_FFFF, lat, rd, err, wes);
    checks++; if (err !== 1'b1 || wes !== 0 || lat !== 1) begin failures++; $display("FAIL sh_over_top got=err%b/we%0d/lat%0d exp=1/0/1", err, wes, lat); end
    do_req(1'b1, 3'b100, 32'h1000, 32'hFFFF_FFFF, lat, rd, err, wes);
    checks++; if (err !== 1'b1 || wes !== 0) begin failures++; $display("FAIL store_f3_100 got=err%b/we%0d exp=1/0", err, wes); end
    do_req(1'b0, 3'b000, 32'h1FFF, 32'h0, lat, rd, err, wes);
    checks++; if (err !== 1'b0 || lat !== 2) begin failures++; $display("FAIL lb_at_top got=err%b/lat%0d exp=0/2", err, lat); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic got_first;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h1000; bus.req_wdata = '0;
    @(posedge clk);
    #1 bus.req_addr = 32'h1004;  // held request, must wait for IDLE
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b exp=0", bus.req_ready); end
    got_first = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin got_first = 1'b1; break; end
    end
    checks++; if (!got_first || bus.resp_rdata !== 32'h1234_5678) begin failures++; $display("FAIL b2b_first got=%b/%h exp=1/12345678", got_first, bus.resp_rdata); end
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin n = i; break; end
    end
    bus.req_valid = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL b2b_gap got=%0d exp=3", n); end
    checks++; if (bus.resp_rdata !== 32'h8001_0080) begin failures++; $display("FAIL b2b_second got=%h exp=80010080", bus.resp_rdata); end
  endtask

  task automatic test_reset_mid();
    int seen;
    set_word(32'h1020, 32'h0102_0304);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h1020; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL mid_wr_we got=%b exp=1", bus.mem_we); end
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL mid_reset_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_ready got=%b exp=1", bus.req_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_reset_resp got=%0d exp=0", seen); end
    checks++; if (get_word(32'h1020) !== 32'h0102_0304) begin failures++; $display("FAIL mid_reset_ram got=%h exp=01020304", get_word(32'h1020)); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    we_count = 0;
    for (int i = 0; i < 4099; i++) ram[i] = 8'h00;
    test_reset();
    test_lw();
    test_lb_lh();
    test_sb_sh_rmw();
    test_sw_lw_top();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
